// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_responder
// Description : Memory-bus slave for a multiplexed 8-bit address/data CPU bus.
//               It serves a small RAM, a reset vector, and fill data for
//               unmapped addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_responder #(
    parameter int          RAM_AW    = 6,
    parameter logic [15:0] RESET_VEC = 16'h0200,
    parameter logic [7:0]  FILL      = 8'hEA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] cpu_ad,
    input  logic [1:0] cpu_phase,
    input  logic       cpu_rw,
    input  logic       cpu_strb,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] bus_oe,
    output logic       err,
    output logic [7:0] txn_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GOT_LO = 2'd1;
    localparam logic [1:0] GOT_HI = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] PH_LO   = 2'd0;
    localparam logic [1:0] PH_HI   = 2'd1;
    localparam logic [1:0] PH_DATA = 2'd2;

    logic [1:0]  state;
    logic [15:0] addr;
    logic [7:0]  ram [0:(2**RAM_AW)-1];
    logic        accept;
    logic        in_ram;
    logic        wr_en;
    logic [7:0]  lookup;

    assign accept = cpu_strb & ena;
    assign in_ram = (addr >> RAM_AW) == 16'd0;
    assign wr_en  = accept && (state == GOT_HI) && (cpu_phase == PH_DATA)
                    && !cpu_rw && in_ram;

    always_comb begin
        lookup = FILL;
        if (in_ram)
            lookup = ram[addr[RAM_AW-1:0]];
        else if (addr == 16'hFFFC)
            lookup = RESET_VEC[7:0];
        else if (addr == 16'hFFFD)
            lookup = RESET_VEC[15:8];
    end

    // The response cycle depends only on state, so an in-flight pulse finishes even with ena low.
    assign rd_valid = (state == RESP);
    assign bus_oe   = {8{rd_valid}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr    <= 16'd0;
            rd_data <= 8'd0;
            err     <= 1'b0;
            txn_cnt <= 8'd0;
        end else begin
            if (state == RESP) begin
                state   <= IDLE;
                txn_cnt <= txn_cnt + 8'd1;
            end
            // Later assignments override the RESP exit, so a strobe in RESP decodes as from IDLE.
            if (accept) begin
                case (cpu_phase)
                    PH_LO: begin
                        addr[7:0] <= cpu_ad;
                        state     <= GOT_LO;
                    end
                    PH_HI: begin
                        if (state == GOT_LO) begin
                            addr[15:8] <= cpu_ad;
                            state      <= GOT_HI;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    PH_DATA: begin
                        if (state == GOT_HI) begin
                            if (cpu_rw) begin
                                rd_data <= lookup;
                                state   <= RESP;
                            end else begin
                                state   <= IDLE;
                                txn_cnt <= txn_cnt + 8'd1;
                            end
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // RAM has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            ram[addr[RAM_AW-1:0]] <= cpu_ad;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_responder
// Description : Directed self-checking bench for mem_bus_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] cpu_ad;
    logic [1:0] cpu_phase;
    logic       cpu_rw;
    logic       cpu_strb;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] bus_oe;
    logic       err;
    logic [7:0] txn_cnt;

    int checks   = 0;
    int failures = 0;

    mem_bus_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .cpu_ad    (cpu_ad),
        .cpu_phase (cpu_phase),
        .cpu_rw    (cpu_rw),
        .cpu_strb  (cpu_strb),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .bus_oe    (bus_oe),
        .err       (err),
        .txn_cnt   (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe, driven and released on falling edges.
    task automatic strobe(input logic [1:0] ph, input logic [7:0] ad, input logic rw);
        @(negedge clk);
        cpu_phase = ph;
        cpu_ad    = ad;
        cpu_rw    = rw;
        cpu_strb  = 1'b1;
        @(negedge clk);
        cpu_strb  = 1'b0;
    endtask

    task automatic write_bus(input logic [15:0] a, input logic [7:0] d);
        strobe(2'd0, a[7:0], 1'b0);
        strobe(2'd1, a[15:8], 1'b0);
        strobe(2'd2, d, 1'b0);
    endtask

    task automatic finish_read(input string tag, input logic [7:0] hi, input logic [7:0] exp);
        strobe(2'd1, hi, 1'b1);
        strobe(2'd2, 8'h00, 1'b1);
        chk({tag, "_valid"}, {15'd0, rd_valid}, 16'd1);
        chk({tag, "_data"},  {8'd0, rd_data}, {8'd0, exp});
        chk({tag, "_oe"},    {8'd0, bus_oe}, 16'h00FF);
        @(negedge clk);
        chk({tag, "_valid_end"}, {15'd0, rd_valid}, 16'd0);
        chk({tag, "_oe_end"},    {8'd0, bus_oe}, 16'h0000);
    endtask

    task automatic read_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        strobe(2'd0, a[7:0], 1'b1);
        finish_read(tag, a[15:8], exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; ena = 1'b1; cpu_ad = 8'h00; cpu_phase = 2'd0;
        cpu_rw = 1'b1; cpu_strb = 1'b0;
        do_reset();
        chk("rst_valid", {15'd0, rd_valid}, 16'd0);
        chk("rst_oe",    {8'd0, bus_oe}, 16'd0);
        chk("rst_err",   {15'd0, err}, 16'd0);
        chk("rst_txn",   {8'd0, txn_cnt}, 16'd0);
        chk("rst_data",  {8'd0, rd_data}, 16'd0);

        // Write then read back.
        write_bus(16'h0012, 8'h5A);
        chk("wr_txn", {8'd0, txn_cnt}, 16'd1);
        read_chk("rb12", 16'h0012, 8'h5A);
        chk("rb_txn", {8'd0, txn_cnt}, 16'd2);

        // Vector and unmapped space.
        read_chk("vec_lo", 16'hFFFC, 8'h00);
        read_chk("vec_hi", 16'hFFFD, 8'h02);
        read_chk("unmap",  16'h1234, 8'hEA);
        write_bus(16'h1234, 8'h77);
        read_chk("unmap_wr", 16'h1234, 8'hEA);
        chk("vec_txn", {8'd0, txn_cnt}, 16'd7);

        // Repeated ADDR_LO restarts the address.
        write_bus(16'h0007, 8'h3C);
        strobe(2'd0, 8'h05, 1'b1);
        read_chk("restart", 16'h0007, 8'h3C);
        chk("restart_err", {15'd0, err}, 16'd0);
        chk("restart_txn", {8'd0, txn_cnt}, 16'd9);

        // ADDR_LO during RESP starts the next transaction.
        write_bus(16'h0008, 8'h11);
        strobe(2'd0, 8'h12, 1'b1);
        strobe(2'd1, 8'h00, 1'b1);
        strobe(2'd2, 8'h00, 1'b1);
        cpu_phase = 2'd0; cpu_ad = 8'h08; cpu_strb = 1'b1;
        chk("b2b_valid", {15'd0, rd_valid}, 16'd1);
        chk("b2b_data",  {8'd0, rd_data}, 16'h005A);
        @(negedge clk);
        cpu_strb = 1'b0;
        chk("b2b_txn", {8'd0, txn_cnt}, 16'd11);
        finish_read("b2b2", 8'h00, 8'h11);
        chk("b2b_txn2", {8'd0, txn_cnt}, 16'd12);

        // Protocol errors.
        strobe(2'd2, 8'h00, 1'b1);
        chk("perr_err",   {15'd0, err}, 16'd1);
        chk("perr_valid", {15'd0, rd_valid}, 16'd0);
        @(negedge clk);
        chk("perr_valid2", {15'd0, rd_valid}, 16'd0);
        chk("perr_txn",   {8'd0, txn_cnt}, 16'd12);
        strobe(2'd3, 8'h00, 1'b1);
        chk("ph3_err", {15'd0, err}, 16'd1);
        read_chk("perr_read", 16'h0012, 8'h5A);
        chk("perr_txn2", {8'd0, txn_cnt}, 16'd13);
        chk("perr_sticky", {15'd0, err}, 16'd1);

        // Reset in GOT_HI abandons a pending write.
        strobe(2'd0, 8'h12, 1'b0);
        strobe(2'd1, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0; cpu_phase = 2'd2; cpu_ad = 8'hFF; cpu_rw = 1'b0; cpu_strb = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; cpu_strb = 1'b0;
        chk("mrst_valid", {15'd0, rd_valid}, 16'd0);
        chk("mrst_oe",    {8'd0, bus_oe}, 16'd0);
        chk("mrst_err",   {15'd0, err}, 16'd0);
        chk("mrst_txn",   {8'd0, txn_cnt}, 16'd0);
        chk("mrst_data",  {8'd0, rd_data}, 16'd0);
        read_chk("mrst_ram", 16'h0012, 8'h5A);

        // ena low ignores strobes.
        write_bus(16'h0013, 8'h99);
        strobe(2'd0, 8'h13, 1'b1);
        strobe(2'd1, 8'h00, 1'b1);
        ena = 1'b0;
        strobe(2'd0, 8'h00, 1'b1);
        strobe(2'd2, 8'h00, 1'b1);
        chk("ena_valid", {15'd0, rd_valid}, 16'd0);
        chk("ena_txn",   {8'd0, txn_cnt}, 16'd2);
        ena = 1'b1;
        strobe(2'd2, 8'h00, 1'b1);
        chk("ena_resume_valid", {15'd0, rd_valid}, 16'd1);
        chk("ena_resume_data",  {8'd0, rd_data}, 16'h0099);
        chk("ena_err", {15'd0, err}, 16'd0);

        // Transaction counter wraps.
        do_reset();
        for (int i = 0; i < 255; i++) write_bus(16'h1234, i[7:0]);
        chk("wrap_255", {8'd0, txn_cnt}, 16'd255);
        write_bus(16'h1234, 8'h00);
        chk("wrap_0", {8'd0, txn_cnt}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameter RAM_AW, default 6, sets internal RAM size to 2^RAM_AW bytes mapped at 0x0000 upward.
REQ-002 Parameter RESET_VEC, default 16'h0200, sets the 16-bit value returned for reads of 0xFFFC (low byte) and 0xFFFD (high byte).
REQ-003 Parameter FILL, default 8'hEA, sets the byte returned for reads of unmapped addresses.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port ena, input, 1: block enable; when low, strobes are ignored and all state holds.
REQ-007 Port cpu_ad, input, 8: multiplexed address/data byte from the CPU's bidirectional pins.
REQ-008 Port cpu_phase, input, 2: bus phase qualifier (0 = ADDR_LO, 1 = ADDR_HI, 2 = DATA, 3 = reserved).
REQ-009 Port cpu_rw, input, 1: 1 = read, 0 = write; sampled with the DATA strobe.
REQ-010 Port cpu_strb, input, 1: one-cycle qualifier marking cpu_ad/cpu_phase/cpu_rw valid.
REQ-011 Port rd_data, output, 8: read data returned to the CPU.
REQ-012 Port rd_valid, output, 1: one-cycle pulse marking rd_data valid.
REQ-013 Port bus_oe, output, 8: pin-direction drive; 8'hFF while the responder drives, otherwise 8'h00.
REQ-014 Port err, output, 1: sticky protocol-error flag.
REQ-015 Port txn_cnt, output, 8: count of completed transactions.

Function
REQ-016 FSM states: IDLE, GOT_LO, GOT_HI, RESP. A strobe is accepted only when cpu_strb=1 and ena=1.
REQ-017 ADDR_LO strobe in any state: latch addr[7:0]; go to GOT_LO.
REQ-018 ADDR_HI strobe in GOT_LO: latch addr[15:8]; go to GOT_HI.
REQ-019 DATA strobe in GOT_HI, read: latch the lookup result into rd_data; go to RESP.
REQ-020 DATA strobe in GOT_HI, write: perform the write in the same edge; go to IDLE; increment txn_cnt.
REQ-021 RESP lasts exactly one cycle: rd_valid=1 and bus_oe=8'hFF during it; txn_cnt increments on leaving RESP.
REQ-022 Read latency: rd_valid is high in the cycle immediately after the DATA strobe cycle.
REQ-023 rd_data holds its value until the next read completes.
REQ-024 Read lookup order: addr < 2^RAM_AW returns RAM; 0xFFFC returns RESET_VEC[7:0]; 0xFFFD returns RESET_VEC[15:8]; any other address returns FILL.
REQ-025 Writes to addr < 2^RAM_AW update RAM; all other writes are ignored but still count as completed transactions.
REQ-026 Protocol errors set err=1 and force the FSM to IDLE. These are: ADDR_HI strobe outside GOT_LO; DATA strobe outside GOT_HI; any phase-3 strobe.
REQ-027 A strobe in RESP is decoded as from IDLE, and rd_valid still pulses in that cycle.
REQ-028 txn_cnt wraps from 255 to 0.
REQ-029 err clears only on reset.
REQ-030 ena low mid-transaction freezes the FSM, address and outputs. A rd_valid pulse already in progress completes.

Reset
REQ-031 When rst_n=0 at a clock edge:
- FSM goes to IDLE.
- rd_data, rd_valid, bus_oe, err and txn_cnt go to 0.
- Latched address goes to 0.
- RAM contents are retained.
REQ-032 A reset mid-transaction abandons it: no write, no rd_valid, no txn_cnt increment.

Verification
REQ-033 Write/readback: write 0x5A to 0x0012 via strobes LO=0x12, HI=0x00, DATA rw=0 -> then read 0x0012 -> rd_valid one cycle after DATA, rd_data=0x5A, bus_oe=0xFF for that cycle only, txn_cnt=2.
REQ-034 Vector/unmapped reads: read 0xFFFC -> 0x00; read 0xFFFD -> 0x02; read 0x1234 -> 0xEA; write 0x77 to 0x1234 then read 0x1234 -> 0xEA.
REQ-035 Protocol error: DATA strobe from IDLE -> err=1, no rd_valid, txn_cnt unchanged. Then a phase-3 strobe -> err stays 1. A subsequent legal read still completes.
REQ-036 Restart/back-to-back: LO=0x05, LO=0x07, HI=0x00, read -> data of 0x0007, err=0. An ADDR_LO strobe in the RESP cycle starts the next transaction without loss.
REQ-037 Reset/enable: assert rst_n=0 in GOT_HI -> all outputs 0 next cycle and RAM byte preserved. Hold ena=0 across strobes -> no state change. Perform 256 writes -> txn_cnt wraps to 0.
